clk_div_multi: RTL and testbench

- Multi-channel, runtime-programmable clock divider and strobe generator.
- Successor to the fixed single-channel divider, generalised to NUM_CH independent channels.
- Each channel produces a square wave clk_out[i] with half-period (div_i+1) clk_in cycles.
- Per-channel divisors are loaded through a valid/ready config port, applied glitch-free at the half-period boundary.
- Global sync re-phases all channels.
- Feeds camera/HDMI timing logic that needs several slow derived clocks or enables from one system clock.

---
 rtl/clk_div_multi.sv | 132 +++++++++++++
 tb/tb_clk_div_multi.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel toggles clk_out every (div+1) enabled cycles.
// Optional rising-edge strobes on tick_out are built when CLK_DIV_TICK_EN is defined.
`timescale 1ns/1ps
module clk_div_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 50,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out
`ifdef CLK_DIV_TICK_EN
    ,
    output logic [NUM_CH-1:0] tick_out
`endif
);

    localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  div_d [NUM_CH];
    logic [CNT_W-1:0]  shd_q [NUM_CH];
    logic [CNT_W-1:0]  shd_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] clk_q, clk_d;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] clear;
    logic [NUM_CH-1:0] bnd;
    logic [NUM_CH-1:0] apply;

    // Config handshake: a request is accepted when cfg_valid and cfg_ready are both high
    // on a rising clk_in edge. An index with no channel behind it is always ready and the
    // write is dropped; a channel still holding a pending divisor stalls further writes.
    always_comb begin
        cfg_ready = 1'b1;
        hit       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend_q[i];
                hit[i]    = cfg_valid & ~pend_q[i];
            end
        end
    end

    always_comb begin
        clear  = '0;
        bnd    = '0;
        apply  = '0;
        clk_d  = clk_q;
        pend_d = pend_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            div_d[i] = div_q[i];
            shd_d[i] = shd_q[i];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            clear[i] = sync | ~en[i];
            bnd[i]   = ~clear[i] & (cnt_q[i] == div_q[i]);
            // hit and apply are disjoint: hit needs pend clear, apply needs pend set.
            apply[i] = pend_q[i] & (clear[i] | bnd[i]);

            if (clear[i] | bnd[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end

            if (clear[i]) begin
                clk_d[i] = 1'b0;
            end else if (bnd[i]) begin
                clk_d[i] = ~clk_q[i];
            end

            if (apply[i]) begin
                div_d[i] = shd_q[i];
            end
            if (hit[i]) begin
                shd_d[i] = cfg_div;
            end
            pend_d[i] = hit[i] | (pend_q[i] & ~apply[i]);
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DEF_DIV_V;
                shd_q[i] <= DEF_DIV_V;
            end
            pend_q <= '0;
            clk_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
                shd_q[i] <= shd_d[i];
            end
            pend_q <= pend_d;
            clk_q  <= clk_d;
        end
    end

    assign clk_out = clk_q;

`ifdef CLK_DIV_TICK_EN
    logic [NUM_CH-1:0] tick_q;

    // A boundary seen while the output is low is exactly the 0->1 transition.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= bnd & ~clk_q;
        end
    end

    assign tick_out = tick_q;
`else
    // Strobe outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed sequences, a vector table and a random phase,
// all compared against a cycle-level reference model of the divider rules.
`timescale 1ns/1ps
module tb_clk_div_multi;

    // Six channels so that indices 6 and 7 exist on cfg_ch but map to no channel.
    localparam int NUM_CH  = 6;
    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 50;
    localparam int CH_W    = 3;

    logic              clk_in    = 1'b0;
    logic              reset     = 1'b0;
    logic [NUM_CH-1:0] en        = '0;
    logic              sync      = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [CH_W-1:0]   cfg_ch    = '0;
    logic [CNT_W-1:0]  cfg_div   = '0;
    logic              cfg_ready;
    logic [NUM_CH-1:0] clk_out;
`ifdef CLK_DIV_TICK_EN
    logic [NUM_CH-1:0] tick_out;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    clk_div_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DEF_DIV(DEF_DIV)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (en),
        .sync     (sync),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .clk_out  (clk_out)
`ifdef CLK_DIV_TICK_EN
        ,
        .tick_out (tick_out)
`endif
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded 1ms, required to finish earlier");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: elapsed enabled cycles in the current half-period, which ends
    // once it reaches div+1.
    int m_el   [NUM_CH];
    int m_div  [NUM_CH];
    int m_sh   [NUM_CH];
    bit m_pend [NUM_CH];
    bit m_clk  [NUM_CH];
    bit m_tick [NUM_CH];

    function automatic bit model_ready(input int ch);
        if (ch >= NUM_CH) return 1'b1;
        return !m_pend[ch];
    endfunction

    function automatic logic [NUM_CH-1:0] model_clk();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = m_clk[i];
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] model_tick();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = m_tick[i];
        return r;
    endfunction

    always @(posedge clk_in or negedge reset) begin : model
        bit acc;
        int ach;
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_el[c] = 0; m_div[c] = DEF_DIV; m_sh[c] = DEF_DIV;
                m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
            end
        end else begin
            ach = int'(cfg_ch);
            acc = cfg_valid && model_ready(ach);
            for (int c = 0; c < NUM_CH; c++) begin
                m_tick[c] = 0;
                if (sync || !en[c]) begin
                    m_el[c]  = 0;
                    m_clk[c] = 0;
                    if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
                end else begin
                    m_el[c]++;
                    if (m_el[c] == m_div[c] + 1) begin
                        m_el[c]   = 0;
                        m_clk[c]  = !m_clk[c];
                        m_tick[c] = m_clk[c];
                        if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
                    end
                end
            end
            if (acc && ach < NUM_CH) begin
                m_sh[ach]   = int'(cfg_div);
                m_pend[ach] = 1;
            end
        end
    end

    // Continuous scoreboard, sampled mid-low-phase after the inputs have settled.
    always begin
        @(negedge clk_in);
        #2;
        check("model_clk_out", clk_out, model_clk());
        check("model_cfg_ready", cfg_ready, model_ready(int'(cfg_ch)));
`ifdef CLK_DIV_TICK_EN
        check("model_tick_out", tick_out, model_tick());
`endif
    end

    task automatic cfg_write(input int ch, input int dv, output int waited);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(dv);
        waited    = 0;
        #1;
        while (cfg_ready !== 1'b1 && waited < 300) begin
            @(negedge clk_in);
            #1;
            waited++;
        end
        if (waited >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL cfg_wait: ch %0d ready=%b after %0d cycles, required 1", ch, cfg_ready, waited);
        end
        @(negedge clk_in);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_level(input int ch, input logic lvl, output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (clk_out[ch] !== lvl && n < 1000);
    endtask

    typedef struct {
        int ch;
        int div;
        int exp_first;
        int exp_half;
    } vec_t;

    vec_t vecs[6];
    int   divs4[4];
    int   first_r[4];
    int   n, w, t0;

    initial begin
        vecs[0] = '{ch: 0, div: 0,   exp_first: 1,   exp_half: 1};
        vecs[1] = '{ch: 1, div: 1,   exp_first: 2,   exp_half: 2};
        vecs[2] = '{ch: 2, div: 4,   exp_first: 5,   exp_half: 5};
        vecs[3] = '{ch: 3, div: 13,  exp_first: 14,  exp_half: 14};
        vecs[4] = '{ch: 4, div: 255, exp_first: 256, exp_half: 256};
        vecs[5] = '{ch: 5, div: 99,  exp_first: 100, exp_half: 100};
        divs4   = '{5, 7, 9, 11};

        // Reset state and release
        #1;
        check("reset_clk_out", clk_out, 0);
`ifdef CLK_DIV_TICK_EN
        check("reset_tick_out", tick_out, 0);
`endif
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        #1;
        check("release_cfg_ready", cfg_ready, 1);
        check("release_clk_out", clk_out, 0);
        @(negedge clk_in);

        // Default divisor on channel 0
        en = 6'b000001;
        wait_level(0, 1'b1, n); check("def_first_rise", n, 51);
        wait_level(0, 1'b0, n); check("def_high_half", n, 51);
        wait_level(0, 1'b1, n); check("def_low_half", n, 51);
        check("def_other_ch_low", clk_out[5:1], 0);

        // Divisor change mid half-period on channel 1
        en = 6'b000011;
        t0 = cyc;
        repeat (20) @(negedge clk_in);
        cfg_write(1, 3, w);
        check("ch1_write_wait", w, 0);
        cfg_ch = 3'd1;
        #1;
        check("ch1_ready_pending", cfg_ready, 0);
        cfg_write(2, 0, w);
        check("ch2_write_in_window", w, 0);
        wait_level(1, 1'b1, n);
        check("ch1_first_rise_kept", cyc - t0, 51);
        cfg_ch = 3'd1;
        #1;
        check("ch1_ready_after_bnd", cfg_ready, 1);
        wait_level(1, 1'b0, n); check("ch1_new_high", n, 4);
        wait_level(1, 1'b1, n); check("ch1_new_low", n, 4);

        // Divide-by-two on channel 2
        @(negedge clk_in);
        en = 6'b000111;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            check("div0_toggle", clk_out[2], k % 2);
`ifdef CLK_DIV_TICK_EN
            check("div0_tick", tick_out[2], k % 2);
`endif
        end

        // Sync re-phase of four running channels
        en = '0;
        for (int i = 0; i < 4; i++) cfg_write(i, divs4[i], w);
        @(negedge clk_in);
        en = 6'b001111;
        repeat (30) @(negedge clk_in);
        sync = 1'b1;
        @(negedge clk_in);
        sync = 1'b0;
        check("sync_clears", clk_out[3:0], 0);
        for (int i = 0; i < 4; i++) first_r[i] = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_in);
            for (int i = 0; i < 4; i++) begin
                if (first_r[i] == 0 && clk_out[i]) first_r[i] = k;
            end
        end
        for (int i = 0; i < 4; i++) check("sync_first_rise", first_r[i], divs4[i] + 1);

        // Async reset with a divisor pending on channel 1
        wait_level(3, 1'b0, n);
        wait_level(3, 1'b1, n);
        cfg_write(1, 20, w);
        cfg_ch = 3'd1;
        #1;
        check("rst_pend_ready", cfg_ready, 0);
        check("rst_pre_clk3", clk_out[3], 1);
        reset = 1'b0;
        #1;
        check("rst_async_clk_out", clk_out, 0);
        check("rst_async_ready", cfg_ready, 1);
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
        wait_level(1, 1'b1, n);
        check("rst_ch1_default_div", n, 51);

        // Out-of-range channel indices
        cfg_write(7, 2, w);
        check("oor7_accept_wait", w, 0);
        cfg_write(6, 3, w);
        check("oor6_accept_wait", w, 0);
        wait_level(1, 1'b0, n);
        check("oor_no_timing_change", n, 49);

        // Table of divisors, each channel alone from a cleared state
        en = '0;
        @(negedge clk_in);
        for (int v = 0; v < 6; v++) begin
            cfg_write(vecs[v].ch, vecs[v].div, w);
            @(negedge clk_in);
            en = NUM_CH'(1) << vecs[v].ch;
            wait_level(vecs[v].ch, 1'b1, n); check("tbl_first_rise", n, vecs[v].exp_first);
            wait_level(vecs[v].ch, 1'b0, n); check("tbl_high_half", n, vecs[v].exp_half);
            en = '0;
            @(negedge clk_in);
        end

        // Random traffic, checked only by the reference model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_in);
            if ($urandom_range(0, 15) == 0) en = NUM_CH'($urandom);
            sync      = ($urandom_range(0, 39) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CH_W'($urandom_range(0, 7));
            cfg_div   = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 255))
                                                    : CNT_W'($urandom_range(0, 12));
        end
        @(negedge clk_in);
        sync      = 1'b0;
        cfg_valid = 1'b0;
        en        = '0;
        repeat (4) @(negedge clk_in);
        check("final_all_low", clk_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
